// File: rtl/ling_knowles_sub_if.sv
// Handshake and operand/result bundle for the pipelined Ling/Knowles subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface ling_knowles_sub_if #(
    parameter int unsigned WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/ling_knowles_sub_pipe.sv
// Three-stage pipelined subtractor a - b - bin built on a Ling-form Knowles prefix tree.
// Prefix spans 1/2/4/8 cover at most 16 positions, so WIDTH must not exceed 15.
module ling_knowles_sub_pipe #(
    parameter int unsigned WIDTH = 12
) (
    input logic              clk,
    input logic              rst,
    ling_knowles_sub_if.slave bus
);
    localparam int unsigned N = WIDTH + 1;  // bit 0 carries cin

    // Stage valids and load enables
    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;

    assign ld3 = ~v3_q | bus.out_ready;
    assign ld2 = ~v2_q | ld3;
    assign ld1 = ~v1_q | ld2;

    assign bus.in_ready = ld1 & ~rst;

    // Stage 1: pre-computation of propagate/generate, cin folded in as bit 0
    logic [N-1:0] p_in, g_in;
    logic [N-1:0] p1_q, g1_q;
    logic         am1_q, bm1_q;

    assign p_in = {bus.a | ~bus.b, 1'b1};
    assign g_in = {bus.a & ~bus.b, ~bus.bin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            p1_q  <= '0;
            g1_q  <= '0;
            am1_q <= 1'b0;
            bm1_q <= 1'b0;
        end else if (ld1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                p1_q  <= p_in;
                g1_q  <= g_in;
                am1_q <= bus.a[WIDTH-1];
                bm1_q <= bus.b[WIDTH-1];
            end
        end
    end

    // Stage 2: reduced span-1 Ling cells, then span-2 cells
    logic [N-1:0]     h1, i1, h2, i2;
    logic [WIDTH-1:0] t1;
    logic [N-1:0]     h2_q, i2_q, p2_q;
    logic [WIDTH-1:0] t2_q;
    logic             am2_q, bm2_q;

    assign h1 = g1_q | (g1_q << 1);
    assign i1 = (p1_q << 1) & (p1_q << 2);
    assign h2 = h1 | (i1 & (h1 << 2));
    assign i2 = i1 & (i1 << 2);
    // Half-sum a ^ ~b recovered from p and g
    assign t1 = p1_q[N-1:1] & ~g1_q[N-1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            h2_q  <= '0;
            i2_q  <= '0;
            p2_q  <= '0;
            t2_q  <= '0;
            am2_q <= 1'b0;
            bm2_q <= 1'b0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                h2_q  <= h2;
                i2_q  <= i2;
                p2_q  <= p1_q;
                t2_q  <= t1;
                am2_q <= am1_q;
                bm2_q <= bm1_q;
            end
        end
    end

    // Stage 3: span-4 and span-8 cells, carry recovery and result flags
    logic [N-1:0]     h4, i4, h8, c;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d, zero_d, ovf_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, zero_q, ovf_q;

    assign h4 = h2_q | (i2_q & (h2_q << 4));
    assign i4 = i2_q & (i2_q << 4);
    assign h8 = h4 | (i4 & (h4 << 8));
    // Real carry out of position k is p[k] & H[k:0]
    assign c  = p2_q & h8;

    assign diff_d = t2_q ^ c[WIDTH-1:0];
    assign bout_d = ~c[WIDTH];
    assign zero_d = (diff_d == '0);
    assign ovf_d  = (am2_q != bm2_q) & (diff_d[WIDTH-1] != am2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ld3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
endmodule
